// File: rtl/fifo_rd_streamer.sv
// Read-side stage for the synchronous FIFO: turns its rd_en/data-next-cycle pull
// interface into a valid/ready stream through a 3-entry skid buffer, with burst framing.
module fifo_rd_streamer #(
  parameter int FIFO_WIDTH = 16,
  parameter int BURST_LEN  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_rd_en,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  input  logic                  fifo_underflow,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      beat_cnt,
  output logic                  err
);

  localparam int BI_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BI_W-1:0] BURST_END = BI_W'(BURST_LEN - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                state_q, state_d;
  logic [1:0]            occ_q, occ_d;
  logic [1:0]            wr_ptr_q, rd_ptr_q;
  logic                  inflight_q;
  logic [BI_W-1:0]       burst_idx_q;
  logic [CNT_W-1:0]      beat_cnt_q;
  logic                  err_q;
  logic [FIFO_WIDTH-1:0] mem_q [3];

  logic capture, pop, room;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Room counts reads already in flight, so a capture can never find the buffer full.
  assign room       = ({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3;
  assign fifo_rd_en = (state_q == RUN) && en && !fifo_empty && room && !rst;
  assign capture    = inflight_q;
  assign m_valid    = (occ_q != 2'd0);
  assign m_data     = mem_q[rd_ptr_q];
  assign pop        = m_valid && m_ready;
  assign m_last     = m_valid && (burst_idx_q == BURST_END);
  assign busy       = (state_q != IDLE);
  assign beat_cnt   = beat_cnt_q;
  assign err        = err_q;

  always_comb begin
    occ_d = occ_q;
    unique case ({capture, pop})
      2'b10:   occ_d = occ_q + 2'd1;
      2'b01:   occ_d = occ_q - 2'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (en) state_d = RUN;
      RUN:     if (!en) state_d = DRAIN;
      DRAIN: begin
        if (en)                                  state_d = RUN;
        else if (occ_q == 2'd0 && !inflight_q)   state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      occ_q       <= 2'd0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      inflight_q  <= 1'b0;
      burst_idx_q <= '0;
      beat_cnt_q  <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < 3; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      occ_q      <= occ_d;
      inflight_q <= fifo_rd_en;
      if (capture) begin
        mem_q[wr_ptr_q] <= fifo_data_out;
        wr_ptr_q        <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q    <= ptr_inc(rd_ptr_q);
        burst_idx_q <= (burst_idx_q == BURST_END) ? '0 : burst_idx_q + 1'b1;
        beat_cnt_q  <= beat_cnt_q + 1'b1;
      end
      if (fifo_underflow || (capture && occ_q == 2'd3)) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_rd_streamer.sv
// Bench for fifo_rd_streamer: a queue-backed FIFO model feeds the DUT and a
// negedge monitor logs every accepted beat for the scenario tasks to check.
module tb_fifo_rd_streamer;

  localparam int W  = 16;
  localparam int BL = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          en = 1'b0;
  logic          m_ready = 1'b0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_data_out = '0;
  logic          fifo_empty;
  logic          fifo_underflow = 1'b0;
  logic          m_valid, m_last, busy, err;
  logic [W-1:0]  m_data;
  logic [CW-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_rd_streamer #(.FIFO_WIDTH(W), .BURST_LEN(BL), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en),
    .fifo_rd_en(fifo_rd_en), .fifo_data_out(fifo_data_out),
    .fifo_empty(fifo_empty), .fifo_underflow(fifo_underflow),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .beat_cnt(beat_cnt), .err(err)
  );

  // Upstream FIFO model: words pushed by tasks, popped on rd_en, data one cycle later.
  logic [W-1:0] fmem [0:8191];
  int   fhead = 0;
  int   ftail = 0;
  logic flush_req = 1'b0;
  assign fifo_empty = (fhead == ftail);

  always @(posedge clk) begin
    if (flush_req) begin
      fhead <= ftail;
      fifo_underflow <= 1'b0;
    end else if (fifo_rd_en) begin
      if (fhead == ftail) fifo_underflow <= 1'b1;
      else begin
        fifo_data_out  <= fmem[fhead];
        fhead          <= fhead + 1;
        fifo_underflow <= 1'b0;
      end
    end else fifo_underflow <= 1'b0;
  end

  // Monitor: accepted beats, expected framing (every BL-th beat since reset), rd_en pulses.
  logic [W-1:0] out_q[$];
  logic         last_q[$];
  logic         lastexp_q[$];
  int           cyc_q[$];
  int           cyc = 0;
  int           rd_cnt = 0;
  int           pop_total = 0;

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (fifo_rd_en) rd_cnt <= rd_cnt + 1;
    if (rst) pop_total <= 0;
    else if (m_valid && m_ready) begin
      out_q.push_back(m_data);
      last_q.push_back(m_last);
      lastexp_q.push_back((pop_total % BL) == BL - 1);
      cyc_q.push_back(cyc);
      pop_total <= pop_total + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [W-1:0] v);
    fmem[ftail] = v;
    ftail = ftail + 1;
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; m_ready = 1'b0; flush_req = 1'b1;
    tick(); tick();
    flush_req = 1'b0; rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; m_ready = 1'b1; flush_req = 1'b1;
    push(16'h7777);
    tick(); tick();
    @(negedge clk);
    checks++; if (fifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", fifo_rd_en); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid got %b want 0", m_valid); end
    checks++; if (m_data !== 16'h0) begin errors++; $display("FAIL reset_m_data got %h want 0000", m_data); end
    checks++; if (m_last !== 1'b0) begin errors++; $display("FAIL reset_m_last got %b want 0", m_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (beat_cnt !== 8'h0) begin errors++; $display("FAIL reset_beat_cnt got %0d want 0", beat_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
    do_reset();
  endtask

  task automatic test_stream();
    int base, k;
    do_reset();
    base = out_q.size();
    for (int i = 1; i <= 8; i++) push(W'(i));
    en = 1'b1; m_ready = 1'b1;
    k = 0;
    while (out_q.size() < base + 8 && k < 60) begin tick(); k++; end
    checks++;
    if (out_q.size() < base + 8) begin
      errors++; $display("FAIL stream_timeout got %0d beats want 8", out_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (out_q[base+i] !== W'(i+1)) begin errors++; $display("FAIL stream_data[%0d] got %h want %h", i, out_q[base+i], W'(i+1)); end
        checks++; if (last_q[base+i] !== ((i % BL) == BL-1)) begin errors++; $display("FAIL stream_last[%0d] got %b want %b", i, last_q[base+i], (i % BL) == BL-1); end
        checks++; if (cyc_q[base+i] != cyc_q[base] + i) begin errors++; $display("FAIL stream_gap[%0d] got cycle %0d want %0d", i, cyc_q[base+i], cyc_q[base]+i); end
      end
    end
    tick(); tick();
    checks++; if (beat_cnt !== 8'd8) begin errors++; $display("FAIL stream_beat_cnt got %0d want 8", beat_cnt); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL stream_err got %b want 0", err); end
  endtask

  task automatic test_backpressure();
    int base, rd0, k;
    do_reset();
    base = out_q.size(); rd0 = rd_cnt;
    for (int i = 1; i <= 8; i++) push(W'(i));
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i >= 6) begin
        checks++; if (m_valid !== 1'b1 || m_data !== 16'h0001) begin errors++; $display("FAIL bp_hold cyc %0d got v=%b d=%h want v=1 d=0001", i, m_valid, m_data); end
      end
    end
    checks++; if (rd_cnt - rd0 != 3) begin errors++; $display("FAIL bp_rd_pulses got %0d want 3", rd_cnt - rd0); end
    checks++; if (ftail - fhead != 5) begin errors++; $display("FAIL bp_fifo_left got %0d want 5", ftail - fhead); end
    m_ready = 1'b1;
    k = 0;
    while (out_q.size() < base + 8 && k < 60) begin tick(); k++; end
    tick(); tick(); tick();
    checks++;
    if (out_q.size() != base + 8) begin
      errors++; $display("FAIL bp_count got %0d beats want 8", out_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++; if (out_q[base+i] !== W'(i+1)) begin errors++; $display("FAIL bp_data[%0d] got %h want %h", i, out_q[base+i], W'(i+1)); end
      end
    end
    checks++; if (rd_cnt - rd0 != 8) begin errors++; $display("FAIL bp_rd_total got %0d want 8", rd_cnt - rd0); end
  endtask

  task automatic test_drain();
    int base, rd0, rd_drop, issued, k;
    bit early_idle;
    do_reset();
    base = out_q.size(); rd0 = rd_cnt;
    for (int i = 0; i < 8; i++) push(16'h0021 + W'(i));
    en = 1'b1; m_ready = 1'b1;
    k = 0;
    while (out_q.size() < base + 3 && k < 40) begin tick(); k++; end
    en = 1'b0;
    rd_drop = rd_cnt;
    early_idle = 1'b0;
    k = 0;
    while (busy && k < 40) begin
      tick(); k++;
      if (!busy && (m_valid || out_q.size() - base != rd_drop - rd0)) early_idle = 1'b1;
    end
    issued = rd_cnt - rd0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL drain_busy_timeout got %b want 0", busy); end
    checks++; if (early_idle) begin errors++; $display("FAIL drain_idle_early got 1 want 0"); end
    checks++; if (rd_cnt != rd_drop) begin errors++; $display("FAIL drain_no_reads got %0d want 0", rd_cnt - rd_drop); end
    checks++; if (out_q.size() - base != issued) begin errors++; $display("FAIL drain_emitted got %0d want %0d", out_q.size() - base, issued); end
    checks++; if (ftail - fhead != 8 - issued || issued >= 8) begin errors++; $display("FAIL drain_retained got %0d want %0d (nonzero)", ftail - fhead, 8 - issued); end
    for (int i = 0; i < out_q.size() - base && i < 8; i++) begin
      checks++; if (out_q[base+i] !== 16'h0021 + W'(i)) begin errors++; $display("FAIL drain_data[%0d] got %h want %h", i, out_q[base+i], 16'h0021 + W'(i)); end
    end
  endtask

  task automatic test_empty();
    int k;
    bit saw_rd, saw_v;
    do_reset();
    en = 1'b1; m_ready = 1'b1;
    saw_rd = 1'b0; saw_v = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (fifo_rd_en) saw_rd = 1'b1;
      if (m_valid) saw_v = 1'b1;
    end
    checks++; if (saw_rd) begin errors++; $display("FAIL empty_rd_en got 1 want 0"); end
    checks++; if (saw_v) begin errors++; $display("FAIL empty_m_valid got 1 want 0"); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL empty_err got %b want 0", err); end
    tick();
    push(16'hBEEF);
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd_en && k < 20);
    checks++;
    if (!fifo_rd_en) begin errors++; $display("FAIL empty_rd_timeout got 0 want 1"); end
    else begin
      @(negedge clk);
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL beef_v_plus1 got %b want 0", m_valid); end
      @(negedge clk);
      checks++; if (m_valid !== 1'b1 || m_data !== 16'hBEEF) begin errors++; $display("FAIL beef_v_plus2 got v=%b d=%h want v=1 d=beef", m_valid, m_data); end
    end
    tick();
  endtask

  task automatic test_reset_inflight();
    int base, k;
    do_reset();
    push(16'h0A01); push(16'h0A02);
    en = 1'b1; m_ready = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    base = out_q.size();
    push(16'h5A5A);
    k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd_en && k < 20);
    checks++; if (!fifo_rd_en) begin errors++; $display("FAIL rsti_rd_timeout got 0 want 1"); end
    @(posedge clk); #1;
    rst = 1'b1;
    tick();
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL rsti_m_valid got %b want 0", m_valid); end
    checks++; if (beat_cnt !== 8'd0) begin errors++; $display("FAIL rsti_beat_cnt got %0d want 0", beat_cnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rsti_busy got %b want 0", busy); end
    rst = 1'b0; en = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks++; if (out_q.size() != base) begin errors++; $display("FAIL rsti_ghost got %0d beats want 0", out_q.size() - base); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rsti_err got %b want 0", err); end
  endtask

  task automatic test_random();
    int base, k;
    logic [W-1:0] ref_q[$];
    do_reset();
    base = out_q.size();
    for (int i = 0; i < 1000; i++) begin
      logic [W-1:0] v;
      v = W'($urandom);
      ref_q.push_back(v);
      push(v);
    end
    en = 1'b1;
    k = 0;
    while (out_q.size() < base + 1000 && k < 6000) begin
      m_ready = ($urandom_range(0, 1) == 1);
      tick(); k++;
    end
    m_ready = 1'b0;
    tick(); tick();
    checks++;
    if (out_q.size() != base + 1000) begin
      errors++; $display("FAIL rand_count got %0d want 1000", out_q.size() - base);
    end else begin
      for (int i = 0; i < 1000; i++) begin
        checks++; if (out_q[base+i] !== ref_q[i]) begin errors++; $display("FAIL rand_data[%0d] got %h want %h", i, out_q[base+i], ref_q[i]); end
        checks++; if (last_q[base+i] !== lastexp_q[base+i] || lastexp_q[base+i] !== ((i % BL) == BL-1)) begin errors++; $display("FAIL rand_last[%0d] got %b want %b", i, last_q[base+i], (i % BL) == BL-1); end
      end
    end
    checks++; if (beat_cnt !== 8'(1000 % 256)) begin errors++; $display("FAIL rand_beat_cnt got %0d want %0d", beat_cnt, 1000 % 256); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rand_err got %b want 0", err); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_drain();
    test_empty();
    test_reset_inflight();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1, "timeout");
  end

endmodule
